// File: rtl/posit_mac_acc_pkg.sv
// Shared constants, class codes and FSM state type for the posit dot-product accumulator.
package posit_mac_acc_pkg;

  // Default geometry of the block.
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned EXP_DEF   = 2;
  localparam int unsigned CARRY_DEF = 8;

  // Derived widths as functions so each module can evaluate them for its own parameters.
  function automatic int unsigned regi_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  function automatic int unsigned mts_w(input int unsigned width, input int unsigned exp);
    return width - 3 - exp;
  endfunction

  function automatic int unsigned bias_of(input int unsigned width, input int unsigned exp);
    return (1 << (exp + 1)) * (width - 2);
  endfunction

  function automatic int unsigned qw_of(input int unsigned width, input int unsigned exp,
                                        input int unsigned carry);
    return 2 * bias_of(width, exp) + 2 * mts_w(width, exp) + carry + 3;
  endfunction

  // Product position spans 0..2*BIAS-2.
  function automatic int unsigned pos_w(input int unsigned width, input int unsigned exp);
    return $clog2(2 * bias_of(width, exp));
  endfunction

  // Derived constants for the default geometry.
  localparam int unsigned REGI = regi_w(WIDTH_DEF);
  localparam int unsigned MTS  = mts_w(WIDTH_DEF, EXP_DEF);
  localparam int unsigned BIAS = bias_of(WIDTH_DEF, EXP_DEF);
  localparam int unsigned QW   = qw_of(WIDTH_DEF, EXP_DEF, CARRY_DEF);

  // Operand class codes.
  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] VALID = 2'b01;
  localparam logic [1:0] NAR   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain
  } state_e;

endpackage

// File: rtl/posit_mul_align.sv
// Stage 1: multiplies the two mantissas and computes the fixed-point position of the product.
module posit_mul_align
  import posit_mac_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EXP   = 2,
  localparam int unsigned RegiW = regi_w(WIDTH),
  localparam int unsigned MtsW  = mts_w(WIDTH, EXP),
  localparam int unsigned Bias  = bias_of(WIDTH, EXP),
  localparam int unsigned ProdW = 2 * MtsW + 2,
  localparam int unsigned PosW  = pos_w(WIDTH, EXP)
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             sign_s,
  input  logic             sign_l,
  input  logic [RegiW-1:0] regi_s,
  input  logic [RegiW-1:0] regi_l,
  input  logic [EXP-1:0]   exp_s,
  input  logic [EXP-1:0]   exp_l,
  input  logic [MtsW-1:0]  mts_s,
  input  logic [MtsW-1:0]  mts_l,
  input  logic [1:0]       vld_w,
  input  logic [1:0]       vld_d,
  output logic             vld_o,
  output logic             sign_o,
  output logic [ProdW-1:0] prod_o,
  output logic [PosW-1:0]  pos_o,
  output logic             zero_o,
  output logic             nar_o
);

  logic             vld_q;
  logic             sign_q, sign_d;
  logic [ProdW-1:0] prod_q, prod_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic             zero_q, zero_d;
  logic             nar_q, nar_d;
  int               pos_full;

  // Product, position and class decode of the incoming operand pair.
  always_comb begin
    sign_d   = sign_s ^ sign_l;
    prod_d   = ProdW'({1'b1, mts_s}) * ProdW'({1'b1, mts_l});
    pos_full = (int'($signed(regi_s)) + int'($signed(regi_l))) * (1 << EXP)
             + int'(exp_s) + int'(exp_l) + int'(Bias);
    pos_d    = PosW'(pos_full);
    nar_d    = (vld_w == NAR) || (vld_d == NAR);
    // NaR wins over zero so a NaR operand always poisons the result.
    zero_d   = !nar_d && ((vld_w == ZERO) || (vld_d == ZERO));
  end

  // Stage-1 register: data captured on a transfer, valid follows the transfer strobe.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      sign_q <= 1'b0;
      prod_q <= '0;
      pos_q  <= '0;
      zero_q <= 1'b0;
      nar_q  <= 1'b0;
    end else begin
      vld_q <= en_i;
      if (en_i) begin
        sign_q <= sign_d;
        prod_q <= prod_d;
        pos_q  <= pos_d;
        zero_q <= zero_d;
        nar_q  <= nar_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign sign_o = sign_q;
  assign prod_o = prod_q;
  assign pos_o  = pos_q;
  assign zero_o = zero_q;
  assign nar_o  = nar_q;

endmodule

// File: rtl/posit_mac_acc.sv
// Posit dot-product engine: exact fixed-point (quire) accumulation of len_i decoded products.
module posit_mac_acc
  import posit_mac_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EXP   = 2,
  parameter int unsigned CARRY = 8,
  localparam int unsigned RegiW = regi_w(WIDTH),
  localparam int unsigned MtsW  = mts_w(WIDTH, EXP),
  localparam int unsigned Qw    = qw_of(WIDTH, EXP, CARRY),
  localparam int unsigned ProdW = 2 * MtsW + 2,
  localparam int unsigned PosW  = pos_w(WIDTH, EXP)
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [CARRY-1:0]      len_i,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic                  sign_s,
  input  logic                  sign_l,
  input  logic [RegiW-1:0]      regi_s,
  input  logic [RegiW-1:0]      regi_l,
  input  logic [EXP-1:0]        exp_s,
  input  logic [EXP-1:0]        exp_l,
  input  logic [MtsW-1:0]       mts_s,
  input  logic [MtsW-1:0]       mts_l,
  input  logic [1:0]            vld_w,
  input  logic [1:0]            vld_d,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  nar_o,
  output logic signed [Qw-1:0]  acc_o
);

  state_e           state_q, state_d;
  logic [CARRY-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             done_q, done_d;
  logic [Qw-1:0]    acc_q, acc_d;
  logic             nar_q, nar_d;
  logic [Qw-1:0]    term;
  logic             xfer;
  logic             clr;

  logic             s1_vld;
  logic             s1_sign;
  logic [ProdW-1:0] s1_prod;
  logic [PosW-1:0]  s1_pos;
  logic             s1_zero;
  logic             s1_nar;

  assign in_rdy_o = (state_q == StAccum);
  assign xfer     = in_vld_i && in_rdy_o;
  assign clr      = (state_q == StIdle) && start_i;

  posit_mul_align #(
    .WIDTH (WIDTH),
    .EXP   (EXP)
  ) u_mul_align (
    .clk_i  (clk_i),
    .rstn   (rstn),
    .en_i   (xfer),
    .sign_s (sign_s),
    .sign_l (sign_l),
    .regi_s (regi_s),
    .regi_l (regi_l),
    .exp_s  (exp_s),
    .exp_l  (exp_l),
    .mts_s  (mts_s),
    .mts_l  (mts_l),
    .vld_w  (vld_w),
    .vld_d  (vld_d),
    .vld_o  (s1_vld),
    .sign_o (s1_sign),
    .prod_o (s1_prod),
    .pos_o  (s1_pos),
    .zero_o (s1_zero),
    .nar_o  (s1_nar)
  );

  // Sequencer next state: counts transfers, then holds DRAIN two cycles to retire the pipeline.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i != '0) begin
            cnt_d   = len_i;
            state_d = StAccum;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StAccum: begin
        if (xfer) begin
          cnt_d = cnt_q - CARRY'(1);
          if (cnt_q == CARRY'(1)) begin
            state_d = StDrain;
            drain_d = 1'b0;
          end
        end
      end
      StDrain: begin
        if (drain_q) begin
          state_d = StIdle;
          drain_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // Stage 2: shift the product into place and add or subtract it exactly.
  always_comb begin
    acc_d = acc_q;
    nar_d = nar_q;
    term  = Qw'(s1_prod) << s1_pos;
    if (clr) begin
      acc_d = '0;
      nar_d = 1'b0;
    end else if (s1_vld) begin
      if (s1_nar) begin
        nar_d = 1'b1;
      end else if (!s1_zero) begin
        acc_d = s1_sign ? (acc_q - term) : (acc_q + term);
      end
    end
  end

  // Accumulator and sticky NaR flag.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      nar_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      nar_q <= nar_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign nar_o  = nar_q;
  assign acc_o  = nar_q ? '0 : $signed(acc_q);

endmodule

// File: tb/tb_posit_mac_acc.sv
// Self-checking bench for posit_mac_acc with WIDTH=8, EXP=2, CARRY=8 (1.0 reads as 2^54).
module tb_posit_mac_acc;

  localparam int unsigned QW = 113;

  typedef struct packed {
    logic       sign_s;
    logic       sign_l;
    logic [3:0] regi_s;
    logic [3:0] regi_l;
    logic [1:0] exp_s;
    logic [1:0] exp_l;
    logic [2:0] mts_s;
    logic [2:0] mts_l;
    logic [1:0] vld_w;
    logic [1:0] vld_d;
  } op_t;

  typedef struct packed {
    int            len;
    op_t [3:0]     ops;
    logic [QW-1:0] acc;
    logic          nar;
    logic          stall;
    logic          poke;
  } txn_t;

  typedef struct packed {
    logic [QW-1:0] acc;
    logic          nar;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    len = '0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic          sign_s = 1'b0, sign_l = 1'b0;
  logic [3:0]    regi_s = '0, regi_l = '0;
  logic [1:0]    exp_s = '0, exp_l = '0;
  logic [2:0]    mts_s = '0, mts_l = '0;
  logic [1:0]    vld_w = '0, vld_d = '0;
  logic          busy, done, nar;
  logic [QW-1:0] acc_w;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  exp_t sb[$];
  txn_t vec[8];

  posit_mac_acc #(
    .WIDTH (8),
    .EXP   (2),
    .CARRY (8)
  ) dut (
    .clk_i    (clk),
    .rstn     (rstn),
    .start_i  (start),
    .len_i    (len),
    .in_vld_i (in_vld),
    .in_rdy_o (in_rdy),
    .sign_s   (sign_s),
    .sign_l   (sign_l),
    .regi_s   (regi_s),
    .regi_l   (regi_l),
    .exp_s    (exp_s),
    .exp_l    (exp_l),
    .mts_s    (mts_s),
    .mts_l    (mts_l),
    .vld_w    (vld_w),
    .vld_d    (vld_d),
    .busy_o   (busy),
    .done_o   (done),
    .nar_o    (nar),
    .acc_o    (acc_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done_o pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending result at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_acc", 128'(acc_w), 128'(e.acc));
        chk("sb_nar", 128'(nar), 128'(e.nar));
      end
    end
  end

  function automatic op_t mk(input logic ss, input logic sl, input logic [3:0] rs,
                             input logic [3:0] rl, input logic [1:0] es, input logic [1:0] el,
                             input logic [2:0] ms, input logic [2:0] ml,
                             input logic [1:0] vw, input logic [1:0] vd);
    op_t o;
    o.sign_s = ss; o.sign_l = sl; o.regi_s = rs; o.regi_l = rl;
    o.exp_s  = es; o.exp_l  = el; o.mts_s  = ms; o.mts_l  = ml;
    o.vld_w  = vw; o.vld_d  = vd;
    return o;
  endfunction

  // +/-1.0 times 1.0.
  function automatic op_t one(input logic s);
    return mk(s, 1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 3'd0, 3'd0, 2'b01, 2'b01);
  endfunction

  function automatic txn_t mk_t(input int l, input op_t o0, input op_t o1, input op_t o2,
                                input op_t o3, input logic [QW-1:0] a, input logic n,
                                input logic st, input logic pk);
    txn_t t;
    t.len = l; t.ops[0] = o0; t.ops[1] = o1; t.ops[2] = o2; t.ops[3] = o3;
    t.acc = a; t.nar = n; t.stall = st; t.poke = pk;
    return t;
  endfunction

  task automatic drive_op(input op_t o);
    sign_s = o.sign_s; sign_l = o.sign_l; regi_s = o.regi_s; regi_l = o.regi_l;
    exp_s  = o.exp_s;  exp_l  = o.exp_l;  mts_s  = o.mts_s;  mts_l  = o.mts_l;
    vld_w  = o.vld_w;  vld_d  = o.vld_d;
  endtask

  task automatic run_txn(input txn_t t, input int idx);
    int   sent;
    int   guard;
    int   xfer_cyc;
    int   d0;
    logic phase;
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    len    = 8'(t.len);
    in_vld = 1'b0;
    e.acc  = t.acc;
    e.nar  = t.nar;
    sb.push_back(e);
    @(negedge clk);
    start = t.poke;
    len   = 8'd5;
    chk($sformatf("v%0d_busy", idx), 128'(busy), 128'(1));
    sent = 0; guard = 0; phase = 1'b1; xfer_cyc = 0;
    while (sent < t.len && guard < 100) begin
      drive_op(t.ops[sent]);
      in_vld = t.stall ? phase : 1'b1;
      phase  = ~phase;
      if (in_vld && in_rdy) begin
        sent++;
        xfer_cyc = cyc;
      end
      @(negedge clk);
      guard++;
    end
    start  = 1'b0;
    in_vld = 1'b1;
    chk($sformatf("v%0d_xfers", idx), 128'(sent), 128'(t.len));
    chk($sformatf("v%0d_rdy_drain", idx), 128'(in_rdy), 128'(0));
    d0 = done_cnt;
    for (int k = 0; k < 10 && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
    end
    in_vld = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), 128'(done_cnt - d0), 128'(1));
    chk($sformatf("v%0d_latency", idx), 128'(done_cyc - xfer_cyc), 128'(3));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 128'(done), 128'(0));
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_acc_hold", idx), 128'(acc_w), 128'(t.acc));
    chk($sformatf("v%0d_idle", idx), 128'(busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int c0;
    op_t nar_w;
    op_t zero_d;

    nar_w  = one(1'b0);
    nar_w.vld_w = 2'b10;
    zero_d = one(1'b0);
    zero_d.vld_d = 2'b00;

    vec[0] = mk_t(3, one(1'b0), one(1'b0), one(1'b1), '0, QW'(1) << 54, 1'b0, 1'b0, 1'b0);
    vec[1] = mk_t(1, mk(1'b0, 1'b0, 4'b1010, 4'b1010, 2'd0, 2'd0, 3'd0, 3'd0, 2'b01, 2'b01),
                  '0, '0, '0, QW'(64), 1'b0, 1'b0, 1'b0);
    vec[2] = mk_t(1, mk(1'b0, 1'b0, 4'd5, 4'd5, 2'd3, 2'd3, 3'd7, 3'd7, 2'b01, 2'b01),
                  '0, '0, '0, QW'(225) << 94, 1'b0, 1'b0, 1'b0);
    vec[3] = mk_t(2, nar_w, one(1'b0), '0, '0, '0, 1'b1, 1'b0, 1'b0);
    vec[4] = mk_t(2, zero_d, one(1'b0), '0, '0, QW'(1) << 54, 1'b0, 1'b0, 1'b0);
    // 1.5*1.25 - 1.0 = 0.875 = 56/64.
    vec[5] = mk_t(2, mk(1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 3'd4, 3'd2, 2'b01, 2'b01),
                  one(1'b1), '0, '0, QW'(56) << 48, 1'b0, 1'b0, 1'b0);
    // 64 * 2^-4 = 4.0.
    vec[6] = mk_t(1, mk(1'b0, 1'b0, 4'd1, 4'b1111, 2'd2, 2'd0, 3'd0, 3'd0, 2'b01, 2'b01),
                  '0, '0, '0, QW'(1) << 56, 1'b0, 1'b0, 1'b0);
    // Four times -1.0 with stalls and start_i pokes during ACCUM.
    vec[7] = mk_t(4, one(1'b1), one(1'b1), one(1'b1), one(1'b1), -(QW'(1) << 56), 1'b0,
                  1'b1, 1'b1);

    // Reset state.
    #12;
    chk("rst_rdy", 128'(in_rdy), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_nar", 128'(nar), 128'(0));
    chk("rst_acc", 128'(acc_w), 128'(0));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vec[i], i);

    // len=0: immediate completion clears the previous non-zero result.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd0;
    sb.push_back('{acc: '0, nar: 1'b0});
    d0 = done_cnt;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("len0_done", 128'(done_cnt - d0), 128'(1));
    chk("len0_latency", 128'(done_cyc - c0), 128'(1));
    chk("len0_busy", 128'(busy), 128'(0));

    // Reset after two of four transfers.
    run_txn(vec[1], 8);
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    drive_op(one(1'b0));
    in_vld = 1'b1;
    repeat (2) @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    chk("mid_acc_nonzero", 128'(acc_w != '0), 128'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_rdy", 128'(in_rdy), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    chk("mid_rst_nar", 128'(nar), 128'(0));
    chk("mid_rst_acc", 128'(acc_w), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_done", 128'(done_cnt - d0), 128'(0));
    run_txn(mk_t(1, one(1'b0), '0, '0, '0, QW'(1) << 54, 1'b0, 1'b0, 1'b0), 9);

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_mac_acc.md
POSIT_MAC_ACC -- requirements
Module: posit_mac_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, posit bit width.
REQ-002 SHALL have parameter EXP, default 2, exponent field width.
REQ-003 SHALL have parameter CARRY, default 8, accumulator guard bits; len_i width equals CARRY.
REQ-004 SHALL derive REGI=$clog2(WIDTH)+1, MTS=WIDTH-3-EXP, BIAS=2^(EXP+1)*(WIDTH-2), QW=2*BIAS+2*MTS+CARRY+3.
REQ-005 SHALL use one clock and asynchronous active-low reset:
- clk_i  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  begin a dot product (honoured in IDLE only)
- len_i  in  CARRY  number of products to accumulate
- in_vld_i  in  1  decoded operand pair valid
- in_rdy_o  out  1  block accepts operand pair
- sign_s, sign_l  in  1 each  operand signs
- regi_s, regi_l  in  REGI each, signed  regimes
- exp_s, exp_l  in  EXP each  exponents
- mts_s, mts_l  in  MTS each  mantissa fractions (hidden bit excluded)
- vld_w, vld_d  in  2 each  class code: 00 zero, 01 valid, 10 NaR
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle completion pulse
- nar_o  out  1  result is NaR
- acc_o  out  QW, signed  two's-complement fixed-point sum, LSB weight 2^-(BIAS+2*MTS)

Function
REQ-006 SHALL implement FSM IDLE -> ACCUM -> DRAIN -> IDLE.
REQ-007 IDLE: start_i with len_i!=0 SHALL clear accumulator and NaR flag, load counter=len_i, enter ACCUM next cycle.
REQ-008 IDLE: start_i with len_i==0 SHALL clear accumulator and NaR flag and pulse done_o the next cycle; state stays IDLE.
REQ-009 in_rdy_o SHALL equal (state==ACCUM); transfer occurs on in_vld_i && in_rdy_o; each transfer decrements counter.
REQ-010 The transfer that brings counter to 0 SHALL move state to DRAIN; no further transfers are accepted.
REQ-011 Stage 1 (registered on transfer): psign=sign_s^sign_l; prod=(1.mts_s)*(1.mts_l) as a 2*MTS+2-bit unsigned integer; pos=(regi_s+regi_l)*2^EXP+exp_s+exp_l+BIAS, range 0..2*BIAS-2.
REQ-012 Stage 1 SHALL mark the product zero if either class is 00, and NaR if either class is 10; NaR takes precedence.
REQ-013 Stage 2 SHALL add (psign ? -(prod<<pos) : prod<<pos), sign-extended to QW, to the accumulator; zero products add nothing; NaR sets the sticky NaR flag.
REQ-014 Accumulation SHALL be exact; QW guarantees no overflow for len_i <= 2^CARRY-1; no saturation logic.
REQ-015 DRAIN SHALL last exactly 2 cycles so both pipeline stages retire; done_o SHALL pulse on the cycle the state returns to IDLE.
REQ-016 Total latency SHALL be 3 cycles from the last transfer to done_o.
REQ-017 acc_o and nar_o SHALL hold the final result from done_o until the next accepted start_i; acc_o SHALL read 0 whenever nar_o=1.
REQ-018 start_i outside IDLE SHALL be ignored; in_vld_i without in_rdy_o SHALL be ignored; stalls (in_vld_i low) SHALL not corrupt the pipeline.

Reset
REQ-019 rstn low SHALL asynchronously force state IDLE, counter 0, pipeline valids 0, accumulator 0, in_rdy_o=0, busy_o=0, done_o=0, nar_o=0, acc_o=0.
REQ-020 Reset mid-ACCUM or mid-DRAIN SHALL discard partial sums with no done_o pulse.

Structure
REQ-021 The shared posit package SHALL hold the derived constants REGI, MTS, BIAS, QW, the class-code constants (ZERO=00, VALID=01, NAR=10), and the FSM state enum.
REQ-022 Stage-1 product/position logic SHALL be a sub-module, posit_mul_align; accumulator and FSM stay in the top.

Verification (WIDTH=8, EXP=2, CARRY=8; 1.0 reads acc_o=2^54)
REQ-023 len=3, operand pairs 1.0*1.0, 1.0*1.0, -1.0*1.0 (regi 0, exp 0, mts 0) -> done_o 3 cycles after the third transfer, acc_o=2^54, nar_o=0.
REQ-024 len=1, regi_s=regi_l=-6, exp 0, mts 0 -> pos 0, acc_o=64; then regi 5/5, exp 3/3, mts 7/7 -> pos 94, acc_o=225<<94.
REQ-025 len=2, first pair vld_w=10, second pair 1.0*1.0 -> nar_o=1, acc_o=0; first pair vld_d=00 instead -> acc_o=2^54, nar_o=0.
REQ-026 len=4 with in_vld_i toggled every other cycle and start_i asserted during ACCUM -> exactly 4 transfers, start_i ignored, correct sum; len=0 -> done_o next cycle, acc_o=0.
REQ-027 rstn pulsed low after 2 of 4 transfers -> all outputs 0 immediately, no done_o; a new start then yields a sum that includes only post-reset pairs.
